// File: rtl/branch_pc_unit.sv
// Branch evaluation and program-counter stage for the single-cycle miniRISC datapath.
// Owns pc, the architectural carry flag and the run/halt state that gates fetch.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        carry_we,
  input  logic [3:0]  br_type,
  input  logic [31:0] br_offset,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        link_we,
  output logic        taken,
  output logic        carry_flag,
  output logic        halted
);

  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_BR   = 4'd2;
  localparam logic [3:0] BR_BL   = 4'd3;
  localparam logic [3:0] BR_BCY  = 4'd4;
  localparam logic [3:0] BR_BNCY = 4'd5;
  localparam logic [3:0] BR_BZ   = 4'd6;
  localparam logic [3:0] BR_BNZ  = 4'd7;
  localparam logic [3:0] BR_BLTZ = 4'd8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] seq;
  logic [31:0] rel;
  logic [31:0] reg_target;
  logic [31:0] target;
  logic        cond;
  logic        active;

  // Target arithmetic wraps modulo 2^32; the word offset's top two bits fall off the shift.
  assign seq        = pc + 32'(PC_STEP);
  assign rel        = seq + (br_offset << 2);
  assign reg_target = alu_result & 32'hFFFF_FFFC;

  // Condition and target selection; undefined codes behave as no branch.
  always_comb begin
    cond   = 1'b0;
    target = rel;
    case (br_type)
      BR_B, BR_BL: cond = 1'b1;
      BR_BR: begin
        cond   = 1'b1;
        target = reg_target;
      end
      BR_BCY:  cond = carry_flag;
      BR_BNCY: cond = ~carry_flag;
      BR_BZ:   cond = alu_zero;
      BR_BNZ:  cond = ~alu_zero;
      BR_BLTZ: cond = alu_sign;
      default: cond = 1'b0;
    endcase
  end

  // A halting instruction suppresses any branch encoded alongside it.
  assign active    = (state == RUN) && !stall && !halt;
  assign taken     = active && cond;
  assign link_we   = active && (br_type == BR_BL);
  assign link_addr = seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      carry_flag <= 1'b0;
      state      <= RUN;
      halted     <= 1'b0;
    end else if (state == RUN && !stall) begin
      if (carry_we) begin
        carry_flag <= alu_carry;
      end
      if (halt) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        pc <= taken ? target : seq;
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_sign;
  logic        carry_we;
  logic [3:0]  br_type;
  logic [31:0] br_offset;
  logic        stall;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        link_we;
  logic        taken;
  logic        carry_flag;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_carry;
  logic        m_halted;

  branch_pc_unit dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .carry_we(carry_we),
    .br_type(br_type), .br_offset(br_offset), .stall(stall), .halt(halt),
    .pc(pc), .link_addr(link_addr), .link_we(link_we), .taken(taken),
    .carry_flag(carry_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bt;
    logic [31:0] start_pc;
    logic [31:0] off;
    logic [31:0] alu;
    logic        zero;
    logic        sign;
    logic        exp_taken;
    logic        exp_lwe;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_carry  = 1'b0;
    m_halted = 1'b0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    {alu_result, alu_carry, alu_zero, alu_sign, carry_we} = '0;
    {br_type, br_offset, stall, halt} = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset_pc", pc, 32'h0);
    chk("reset_carry", 32'(carry_flag), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
  endtask

  // Drive one instruction, check combinational outputs, clock it, check registers.
  task automatic apply(input logic [3:0] bt, input logic [31:0] off, input logic [31:0] alu,
                       input logic cwe, input logic ac, input logic z, input logic s,
                       input logic st, input logic h, output logic got_taken);
    logic        e_cond;
    logic        e_taken;
    logic        e_lwe;
    logic [31:0] e_tgt;
    br_type = bt; br_offset = off; alu_result = alu; carry_we = cwe;
    alu_carry = ac; alu_zero = z; alu_sign = s; stall = st; halt = h;
    #2;
    e_tgt = m_pc + 32'd4 + off * 32'd4;
    case (bt)
      4'd1, 4'd3: e_cond = 1'b1;
      4'd2: begin e_cond = 1'b1; e_tgt = alu - (alu % 32'd4); end
      4'd4: e_cond = m_carry;
      4'd5: e_cond = !m_carry;
      4'd6: e_cond = z;
      4'd7: e_cond = !z;
      4'd8: e_cond = s;
      default: e_cond = 1'b0;
    endcase
    e_taken = e_cond && !m_halted && !st && !h;
    e_lwe   = (bt == 4'd3) && !m_halted && !st && !h;
    got_taken = taken;
    chk("taken", 32'(taken), 32'(e_taken));
    chk("link_we", 32'(link_we), 32'(e_lwe));
    chk("link_addr", link_addr, m_pc + 32'd4);
    @(posedge clk);
    #1;
    if (!m_halted && !st) begin
      if (cwe) m_carry = ac;
      if (h) m_halted = 1'b1;
      else m_pc = e_taken ? e_tgt : m_pc + 32'd4;
    end
    chk("pc", pc, m_pc);
    chk("carry_flag", 32'(carry_flag), 32'(m_carry));
    chk("halted", 32'(halted), 32'(m_halted));
  endtask

  task automatic jump_to(input logic [31:0] a);
    logic t;
    apply(4'd2, 32'h0, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
  endtask

  initial begin
    logic t;
    logic [31:0] p0;
    vecs[0]  = '{4'd1, 32'h100, 32'hFFFF_FFFE, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'hFC};
    vecs[1]  = '{4'd3, 32'h20,  32'd3,         32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'h30};
    vecs[2]  = '{4'd2, 32'h40,  32'd5,         32'h2003, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000};
    vecs[3]  = '{4'd6, 32'h40,  32'd1,         32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h48};
    vecs[4]  = '{4'd6, 32'h40,  32'd1,         32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h44};
    vecs[5]  = '{4'd8, 32'h40,  32'd1,         32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h48};
    vecs[6]  = '{4'd8, 32'h40,  32'd1,         32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h44};
    vecs[7]  = '{4'd7, 32'h40,  32'd1,         32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h44};
    vecs[8]  = '{4'd7, 32'h40,  32'd1,         32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h48};
    vecs[9]  = '{4'd9, 32'h40,  32'd1,         32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h44};
    vecs[10] = '{4'd0, 32'h40,  32'd1,         32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h44};
    vecs[11] = '{4'd1, 32'hFFFF_FFFC, 32'd0,   32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{4'd15, 32'h80, 32'd4,         32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h84};

    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Sequential fetch 0,4,8,12
    for (int i = 1; i <= 3; i++) begin
      apply(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
      chk("seq_pc", pc, 32'(4 * i));
    end

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_halted", 32'(halted), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Directed vector table
    foreach (vecs[i]) begin
      jump_to(vecs[i].start_pc);
      apply(vecs[i].bt, vecs[i].off, vecs[i].alu, 1'b0, 1'b0, vecs[i].zero, vecs[i].sign,
            1'b0, 1'b0, t);
      chk($sformatf("vec%0d_taken", i), 32'(t), 32'(vecs[i].exp_taken));
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      if (i == 1) begin
        chk("bl_link_addr_pc", vecs[i].start_pc + 32'd4, 32'h24);
      end
    end

    // Carry flag set, then used next cycle
    do_reset();
    apply(4'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t);
    chk("carry_set", 32'(carry_flag), 32'h1);
    apply(4'd4, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    chk("bcy_taken", 32'(t), 32'h1);
    chk("bcy_pc", pc, 32'h10);
    apply(4'd5, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    chk("bncy_not_taken", 32'(t), 32'h0);

    // Same-cycle update: bcy sees the old flag
    do_reset();
    apply(4'd4, 32'd4, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t);
    chk("bcy_same_cycle_taken", 32'(t), 32'h0);
    chk("bcy_same_cycle_carry", 32'(carry_flag), 32'h1);
    chk("bcy_same_cycle_pc", pc, 32'h4);

    // Stall ignores branch, carry_we and halt
    jump_to(32'h60);
    for (int i = 0; i < 2; i++) begin
      apply(4'd1, 32'd8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t);
      chk("stall_taken", 32'(t), 32'h0);
      chk("stall_pc", pc, 32'h60);
      chk("stall_carry", 32'(carry_flag), 32'h1);
      chk("stall_halted", 32'(halted), 32'h0);
    end
    apply(4'd1, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    chk("post_stall_pc", pc, 32'h68);

    // Halt wins over a branch, then everything is frozen
    jump_to(32'h80);
    apply(4'd1, 32'd8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
    chk("halt_taken", 32'(t), 32'h0);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc", pc, 32'h80);
    for (int i = 0; i < 6; i++) begin
      apply(4'($urandom_range(0, 15)), $urandom, $urandom, 1'b1, ~carry_flag,
            1'($urandom), 1'($urandom), 1'b0, 1'($urandom), t);
      chk("halted_pc_frozen", pc, 32'h80);
      chk("halted_link_we", 32'(link_we), 32'h0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", 32'(halted), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] off;
      if (m_halted && $urandom_range(0, 7) == 0) begin
        do_reset();
      end
      off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
      p0 = pc;
      apply(4'($urandom_range(0, 15)), off, $urandom, 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 59) == 0, t);
      if (m_halted) chk("rand_halt_hold", pc, p0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
